// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: dmem req/ack, pipeline stall, MEM/WB register
// Optional build macro: MEM_STAGE_MISALIGN_TRAP_EN (trap misaligned ld/st instead of word-aligning).
module mem_stage_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int RA_W    = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] rs2_data_in,
    input  logic [RA_W-1:0]   rd_addr_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              RegWrite_in,
    input  logic              MemToReg_in,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [RA_W-1:0]   rd_addr_out,
    output logic              RegWrite_out,
    output logic              MemToReg_out,
    output logic              bus_err_o,
    output logic              misalign_o
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_q, we_q, rw_q, m2r_q, is_load_q;
    logic [DATA_W-1:0] alu_q, wdata_q;
    logic [RA_W-1:0]   rd_q;
    logic [DATA_W-1:0] mem_data_q, alu_out_q;
    logic [RA_W-1:0]   rd_out_q;
    logic              rw_out_q, m2r_out_q, bus_err_q, misalign_q;
    logic              mem_op, trap, timeout;

    assign mem_op  = MemRead_in | MemWrite_in;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign trap        = mem_op & (alu_result_in[1:0] != 2'b00);
    assign dmem_addr_o = req_q ? alu_q[ADDR_W-1:0] : '0;
    assign misalign_o  = misalign_q;
`else
    assign trap        = 1'b0;
    assign dmem_addr_o = req_q ? {alu_q[ADDR_W-1:2], 2'b00} : '0;
    assign misalign_o  = 1'b0;
`endif

    // Stall is gated by rst_n so it drops with reset, not at the next edge.
    assign stall_o = rst_n & ((state_q == S_IDLE) ? (mem_op & ~trap)
                                                  : (~dmem_ack_i & ~timeout));

    assign dmem_req_o     = req_q;
    assign dmem_we_o      = req_q & we_q;
    assign dmem_wdata_o   = (req_q & we_q) ? wdata_q : '0;
    assign mem_data_out   = mem_data_q;
    assign alu_result_out = alu_out_q;
    assign rd_addr_out    = rd_out_q;
    assign RegWrite_out   = rw_out_q;
    assign MemToReg_out   = m2r_out_q;
    assign bus_err_o      = bus_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            is_load_q  <= 1'b0;
            rw_q       <= 1'b0;
            m2r_q      <= 1'b0;
            alu_q      <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            mem_data_q <= '0;
            alu_out_q  <= '0;
            rd_out_q   <= '0;
            rw_out_q   <= 1'b0;
            m2r_out_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            // Bubble unless a branch below captures an instruction.
            mem_data_q <= '0;
            alu_out_q  <= '0;
            rd_out_q   <= '0;
            rw_out_q   <= 1'b0;
            m2r_out_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (trap) begin
                        misalign_q <= 1'b1;
                    end else if (mem_op) begin
                        state_q   <= S_BUSY;
                        req_q     <= 1'b1;
                        cnt_q     <= '0;
                        we_q      <= MemWrite_in;
                        is_load_q <= MemRead_in;
                        alu_q     <= alu_result_in;
                        wdata_q   <= rs2_data_in;
                        rd_q      <= rd_addr_in;
                        rw_q      <= RegWrite_in;
                        m2r_q     <= MemToReg_in;
                    end else begin
                        alu_out_q <= alu_result_in;
                        rd_out_q  <= rd_addr_in;
                        rw_out_q  <= RegWrite_in;
                        m2r_out_q <= MemToReg_in;
                    end
                end
                S_BUSY: begin
                    if (dmem_ack_i) begin
                        state_q    <= S_IDLE;
                        req_q      <= 1'b0;
                        alu_out_q  <= alu_q;
                        mem_data_q <= is_load_q ? dmem_rdata_i : '0;
                        rd_out_q   <= rd_q;
                        rw_out_q   <= rw_q;
                        m2r_out_q  <= m2r_q;
                    end else if (timeout) begin
                        state_q   <= S_IDLE;
                        req_q     <= 1'b0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed scoreboard bench for mem_stage_lsu
module tb_mem_stage_lsu;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_result_in, rs2_data_in, dmem_rdata_i;
    logic [4:0]  rd_addr_in;
    logic        MemRead_in, MemWrite_in, RegWrite_in, MemToReg_in, dmem_ack_i;
    logic        stall_o, dmem_req_o, dmem_we_o, bus_err_o, misalign_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, mem_data_out, alu_result_out;
    logic [4:0]  rd_addr_out;
    logic        RegWrite_out, MemToReg_out;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] mdata;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
    } wb_t;

    wb_t sb[$];
    int  vectors = 0;
    int  errors  = 0;
    int  stalls, reqs;
    logic        we_seen;
    logic [31:0] wdata_seen, addr_seen;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .RA_W(5), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in), .rd_addr_in(rd_addr_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in),
        .MemToReg_in(MemToReg_in), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .mem_data_out(mem_data_out),
        .alu_result_out(alu_result_out), .rd_addr_out(rd_addr_out),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
        .bus_err_o(bus_err_o), .misalign_o(misalign_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] alu, mdata, input logic [4:0] rd, input logic rw, m2r);
        wb_t e;
        e.alu = alu; e.mdata = mdata; e.rd = rd; e.rw = rw; e.m2r = m2r;
        sb.push_back(e);
    endtask

    task automatic check_wb(input string tag);
        wb_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_alu"}, alu_result_out, e.alu);
            chk({tag, "_mdata"}, mem_data_out, e.mdata);
            chk({tag, "_rd"}, {27'd0, rd_addr_out}, {27'd0, e.rd});
            chk({tag, "_rw"}, {31'd0, RegWrite_out}, {31'd0, e.rw});
            chk({tag, "_m2r"}, {31'd0, MemToReg_out}, {31'd0, e.m2r});
        end
    endtask

    task automatic drive(input logic rd_en, wr_en, input logic [31:0] addr, wdata,
                         input logic [4:0] rd, input logic rw, m2r);
        MemRead_in = rd_en; MemWrite_in = wr_en; alu_result_in = addr;
        rs2_data_in = wdata; rd_addr_in = rd; RegWrite_in = rw; MemToReg_in = m2r;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Drive a ld/st (inputs held while stalled); ack in BUSY cycle ack_cycle (-1: never).
    // Returns with outputs of the completing edge visible (posedge + 1).
    task automatic mem_access(input logic st, input logic [31:0] addr, wdata,
                              input logic [4:0] rd, input logic rw, m2r,
                              input int ack_cycle, input logic [31:0] rdata);
        drive(~st, st, addr, wdata, rd, rw, m2r);
        dmem_ack_i = 1'b0;
        stalls = 0; reqs = 0; we_seen = 1'b0; wdata_seen = '0; addr_seen = '0;
        @(negedge clk);
        if (stall_o) stalls++;
        for (int c = 0; c < TIMEOUT + 4; c++) begin
            @(posedge clk); #1;
            dmem_ack_i = 1'b0;
            if (!dmem_req_o) break;
            if (c == ack_cycle) begin
                dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
            end
            @(negedge clk);
            if (c == 0) begin
                we_seen = dmem_we_o; wdata_seen = dmem_wdata_o; addr_seen = dmem_addr_o;
            end
            reqs++;
            if (stall_o) stalls++;
        end
        nop();
    endtask

    initial begin
        rst_n = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
        nop();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_alu", alu_result_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU pass-through
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h1234, 32'd0, 5'd5, 1'b1, 1'b0);
        push(32'h1234, 32'd0, 5'd5, 1'b1, 1'b0);
        @(negedge clk);
        chk("alu_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        check_wb("alu");
        nop();

        // Load, ack in 4th BUSY cycle
        push(32'h100, 32'hDEADBEEF, 5'd7, 1'b1, 1'b1);
        mem_access(1'b0, 32'h100, 32'd0, 5'd7, 1'b1, 1'b1, 3, 32'hDEADBEEF);
        chk("ld_stalls", stalls, 32'd4);
        chk("ld_reqs", reqs, 32'd4);
        chk("ld_addr", addr_seen, 32'h100);
        chk("ld_we", {31'd0, we_seen}, 32'd0);
        check_wb("ld");

        // Store, ack in first BUSY cycle
        push(32'h200, 32'd0, 5'd3, 1'b0, 1'b0);
        mem_access(1'b1, 32'h200, 32'hCAFE, 5'd3, 1'b0, 1'b0, 0, 32'h5555AAAA);
        chk("st_stalls", stalls, 32'd1);
        chk("st_we", {31'd0, we_seen}, 32'd1);
        chk("st_wdata", wdata_seen, 32'hCAFE);
        chk("st_addr", addr_seen, 32'h200);
        check_wb("st");
        chk("st_req_drop", {31'd0, dmem_req_o}, 32'd0);
        chk("st_we_drop", {31'd0, dmem_we_o}, 32'd0);

        // Timeout: no ack ever
        push(32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        mem_access(1'b0, 32'h300, 32'd0, 5'd9, 1'b1, 1'b1, -1, 32'd0);
        chk("to_stalls", stalls, TIMEOUT);
        chk("to_reqs", reqs, TIMEOUT);
        chk("to_err", {31'd0, bus_err_o}, 32'd1);
        check_wb("to");
        @(posedge clk); #1;
        chk("to_err_pulse", {31'd0, bus_err_o}, 32'd0);

        // Ack in the last BUSY cycle wins over timeout
        push(32'h304, 32'h0BADF00D, 5'd10, 1'b1, 1'b1);
        mem_access(1'b0, 32'h304, 32'd0, 5'd10, 1'b1, 1'b1, TIMEOUT - 1, 32'h0BADF00D);
        chk("late_reqs", reqs, TIMEOUT);
        chk("late_err", {31'd0, bus_err_o}, 32'd0);
        check_wb("late");

        // Reset after an ALU op clears MEM/WB at once
        drive(1'b0, 1'b0, 32'h77, 32'd0, 5'd4, 1'b1, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_wb_alu", alu_result_out, 32'd0);
        chk("rst_wb_rw", {31'd0, RegWrite_out}, 32'd0);
        chk("rst_wb_rd", {27'd0, rd_addr_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-BUSY drops the request without a clock edge
        drive(1'b1, 1'b0, 32'h400, 32'd0, 5'd6, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_req", {31'd0, dmem_req_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_busy_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_busy_m2r", {31'd0, MemToReg_out}, 32'd0);
        nop();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h55, 32'd0, 5'd8, 1'b1, 1'b0);
        push(32'h55, 32'd0, 5'd8, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_wb("post_rst");
        nop();

        // Misaligned load
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        push(32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        mem_access(1'b0, 32'h102, 32'd0, 5'd11, 1'b1, 1'b1, 0, 32'h12345678);
        chk("mis_reqs", reqs, 32'd0);
        chk("mis_stalls", stalls, 32'd0);
        chk("mis_flag", {31'd0, misalign_o}, 32'd1);
        check_wb("mis");
        @(posedge clk); #1;
        chk("mis_pulse", {31'd0, misalign_o}, 32'd0);
`else
        push(32'h102, 32'h12345678, 5'd11, 1'b1, 1'b1);
        mem_access(1'b0, 32'h102, 32'd0, 5'd11, 1'b1, 1'b1, 0, 32'h12345678);
        chk("mis_reqs", reqs, 32'd1);
        chk("mis_addr", addr_seen, 32'h100);
        chk("mis_flag", {31'd0, misalign_o}, 32'd0);
        check_wb("mis");
`endif

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
